// File: rtl/cinit_accum.sv
// Multi-operand shifted accumulator producing the NRS c_init value.
// Define CINIT_ACCUM_SAT_EN to clamp the sum at all-ones on overflow instead of wrapping.
module cinit_accum #(
  parameter int WIDTH   = 31,
  parameter int NUM_OPS = 4,
  parameter int SH_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand,
  input  logic [SH_W-1:0]  shift,
  output logic [WIDTH-1:0] sum,
  output logic             done,
  output logic             busy,
  output logic             ovf
);

  localparam int TW = WIDTH + 2**SH_W;
  localparam int CW = $clog2(NUM_OPS + 1);
  localparam logic [CW-1:0] LAST = CW'(NUM_OPS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] count;
  logic [TW-1:0] term;
  logic [WIDTH:0] add;
  logic          add_ovf;

  // Term is built wide enough that no shifted-out bit is lost before the overflow test.
  always_comb begin
    term    = {{(TW-WIDTH){1'b0}}, operand} << shift;
    add     = {1'b0, sum} + {1'b0, term[WIDTH-1:0]};
    add_ovf = (|term[TW-1:WIDTH]) | add[WIDTH];
  end

  assign in_ready = (state == ACC);
  assign done     = (state == DONE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sum   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= ACC;
            sum   <= '0;
            count <= '0;
            ovf   <= 1'b0;
          end
        end
        ACC: begin
          // A start here restarts the burst and drops any operand offered alongside it.
          if (start) begin
            sum   <= '0;
            count <= '0;
            ovf   <= 1'b0;
          end else if (in_valid) begin
            count <= count + CW'(1);
            ovf   <= ovf | add_ovf;
`ifdef CINIT_ACCUM_SAT_EN
            if (!ovf) begin
              if (add_ovf) sum <= '1;
              else         sum <= add[WIDTH-1:0];
            end
`else
            sum <= add[WIDTH-1:0];
`endif
            if (count == LAST) state <= DONE;
          end
        end
        DONE: begin
          if (start) begin
            state <= ACC;
            sum   <= '0;
            count <= '0;
            ovf   <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cinit_accum.sv
// Scoreboard bench for cinit_accum: directed test-plan bursts plus randomized bursts
// checked against an arithmetic reference model.
module tb_cinit_accum;
  localparam int WIDTH   = 31;
  localparam int NUM_OPS = 4;
  localparam int SH_W    = 4;
  localparam logic [63:0] MASK = (64'd1 << WIDTH) - 64'd1;

  logic             clk;
  logic             rst;
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] operand;
  logic [SH_W-1:0]  shift;
  logic [WIDTH-1:0] sum;
  logic             done;
  logic             busy;
  logic             ovf;

  cinit_accum #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .SH_W(SH_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .operand(operand), .shift(shift), .sum(sum), .done(done), .busy(busy), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             ovf;
  } exp_t;

  exp_t        expQ[$];
  int          checks = 0;
  int          fails = 0;
  int          doneCount = 0;
  int          pushCount = 0;
  logic        prevDone = 1'b0;
  logic [63:0] modelSum;
  logic        modelOvf;
  int          modelCount;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expected burst result.
  always @(negedge clk) begin
    if (rst) begin
      if (done) begin
        doneCount++;
        checkOutput("done_single_pulse", prevDone, 0);
        if (expQ.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL unexpected_done: got done=1, expected no pending burst at %0t", $time);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("done_sum", sum, e.sum);
          checkOutput("done_ovf", ovf, e.ovf);
        end
      end
      prevDone = done;
    end else begin
      prevDone = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic modelStart();
    modelSum   = 64'd0;
    modelOvf   = 1'b0;
    modelCount = 0;
  endtask

  // Reference rule: the burst result is the running total of operand*2^shift, with overflow
  // whenever a term or the running total reaches 2^WIDTH.
  task automatic modelAccept(input logic [WIDTH-1:0] op, input int sh);
    logic [63:0] term;
    logic [63:0] total;
    exp_t        e;
    term  = 64'(op) * (64'd1 << sh);
    total = modelSum + (term & MASK);
`ifdef CINIT_ACCUM_SAT_EN
    if (!modelOvf) begin
      if (term > MASK || total > MASK) begin
        modelOvf = 1'b1;
        modelSum = MASK;
      end else begin
        modelSum = total;
      end
    end
`else
    if (term > MASK || total > MASK) modelOvf = 1'b1;
    modelSum = total % (MASK + 64'd1);
`endif
    modelCount++;
    if (modelCount == NUM_OPS) begin
      e.sum = modelSum[WIDTH-1:0];
      e.ovf = modelOvf;
      expQ.push_back(e);
      pushCount++;
    end
  endtask

  task automatic issueStart(input logic withOp, input logic [WIDTH-1:0] op);
    start    = 1'b1;
    in_valid = withOp;
    operand  = op;
    shift    = '0;
    cycle();
    start    = 1'b0;
    in_valid = 1'b0;
    modelStart();
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] op, input int sh, input int gap);
    repeat (gap) cycle();
    checkOutput("in_ready_acc", in_ready, 1);
    operand  = op;
    shift    = SH_W'(sh);
    in_valid = 1'b1;
    modelAccept(op, sh);
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic finishBurst(input string name, input logic [63:0] expSum, input logic expOvf);
    checkOutput({name, "_done"}, done, 1);
    checkOutput({name, "_sum"}, sum, expSum);
    checkOutput({name, "_ovf"}, ovf, expOvf);
    cycle();
    checkOutput({name, "_busy_drop"}, busy, 0);
    checkOutput({name, "_sum_held"}, sum, expSum);
  endtask

  initial begin
    int ops;
    int doneBefore;
    logic [WIDTH-1:0] rop;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; operand = '0; shift = '0;
    modelStart();
    repeat (3) cycle();
    checkOutput("reset_sum", sum, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_ready", in_ready, 0);
    checkOutput("reset_ovf", ovf, 0);
    rst = 1'b1;
    cycle();

    $display("[TB] basic sum");
    issueStart(1'b0, '0);
    checkOutput("start_busy", busy, 1);
    applyStimulus(1, 0, 0);
    applyStimulus(2, 0, 0);
    applyStimulus(3, 0, 0);
    applyStimulus(4, 0, 0);
    finishBurst("basic", 10, 0);

    $display("[TB] shift scaling");
    issueStart(1'b0, '0);
    applyStimulus(5, 10, 0);
    applyStimulus(3, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    finishBurst("shift", 5123, 0);

    $display("[TB] carry overflow");
    issueStart(1'b0, '0);
    applyStimulus(31'h7FFFFFFF, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
`ifdef CINIT_ACCUM_SAT_EN
    finishBurst("carry_ovf", 64'h7FFFFFFF, 1);
`else
    finishBurst("carry_ovf", 0, 1);
`endif

    $display("[TB] shift-out overflow");
    issueStart(1'b0, '0);
    applyStimulus(31'h40000000, 2, 0);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
`ifdef CINIT_ACCUM_SAT_EN
    finishBurst("shiftout_ovf", 64'h7FFFFFFF, 1);
`else
    finishBurst("shiftout_ovf", 0, 1);
`endif

    $display("[TB] gaps and restart");
    issueStart(1'b0, '0);
    applyStimulus(9, 0, 2);
    applyStimulus(9, 0, 3);
    checkOutput("gap_sum", sum, 18);
    issueStart(1'b1, 7);
    checkOutput("restart_sum", sum, 0);
    checkOutput("restart_ready", in_ready, 1);
    doneBefore = doneCount;
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 1);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 2);
    finishBurst("restart", 4, 0);
    checkOutput("restart_done_once", doneCount - doneBefore, 1);

    $display("[TB] start while done");
    issueStart(1'b0, '0);
    repeat (NUM_OPS) applyStimulus(2, 1, 0);
    checkOutput("back2back_done", done, 1);
    issueStart(1'b0, '0);
    checkOutput("back2back_sum_clear", sum, 0);
    checkOutput("back2back_ready", in_ready, 1);
    repeat (NUM_OPS) applyStimulus(3, 0, 0);
    finishBurst("back2back", 12, 0);

    $display("[TB] reset mid-burst");
    issueStart(1'b0, '0);
    applyStimulus(6, 0, 0);
    applyStimulus(6, 0, 0);
    expQ.delete();
    doneBefore = doneCount;
    #2 rst = 1'b0;
    #1;
    checkOutput("midrst_sum", sum, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_ready", in_ready, 0);
    cycle();
    rst = 1'b1;
    modelStart();
    operand = 31'd5; in_valid = 1'b1;
    repeat (3) cycle();
    in_valid = 1'b0;
    checkOutput("midrst_ignored_sum", sum, 0);
    checkOutput("midrst_ignored_ready", in_ready, 0);
    checkOutput("midrst_no_done", doneCount - doneBefore, 0);

    $display("[TB] randomized bursts");
    for (int b = 0; b < 25; b++) begin
      issueStart(1'b0, '0);
      ops = 0;
      while (ops < NUM_OPS) begin
        if ($urandom_range(0, 11) == 0) begin
          issueStart(1'b1, WIDTH'($urandom));
          ops = 0;
        end else begin
          case ($urandom_range(0, 3))
            0:       rop = WIDTH'($urandom_range(0, 1000));
            1:       rop = WIDTH'($urandom);
            2:       rop = 31'h7FFFFFFF - WIDTH'($urandom_range(0, 15));
            default: rop = WIDTH'($urandom_range(0, 65535));
          endcase
          applyStimulus(rop, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : 0,
                        int'($urandom_range(0, 2)));
          ops++;
        end
      end
      if ($urandom_range(0, 1) == 1) cycle();
    end

    repeat (4) cycle();
    checkOutput("scoreboard_drained", 64'(expQ.size()), 0);
    checkOutput("random_final_idle", busy, 0);
    $display("[TB] %0d bursts expected after reset test", pushCount);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
